// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } rx_state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sipo_en.sv
// WIDTH-bit serial-in/parallel-out register with shift enable and sync clear.
module sipo_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over shift; new bits enter at bit 0 so the first bit ends up as MSB.
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= {q[WIDTH-2:0], d};
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial receiver controller: start detect, WIDTH shifts, stop check,
// valid/ready output register with framing-error and overrun pulses.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             bit_en,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             start_det;
  logic             sr_clr;
  logic             sr_en;
  logic             consume;

  assign start_det = (state == IDLE) && bit_en && !a;
  assign sr_clr    = rst || start_det;
  assign sr_en     = (state == SHIFT) && bit_en;
  assign consume   = q_valid && q_ready;

  sipo_en #(.WIDTH(WIDTH)) u_sipo (
    .clk (clk),
    .clr (sr_clr),
    .en  (sr_en),
    .d   (a),
    .q   (sr)
  );

  // FSM, bit counter, output register and handshake; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (consume) q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (cnt == LAST) begin
              // Wrap explicitly so non-power-of-two widths never count past LAST.
              cnt   <= '0;
              state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!a) begin
              frame_err <= 1'b1;
            end else if (!q_valid || q_ready) begin
              // Slot empty or being freed on this same edge: take the word.
              q       <= sr;
              q_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with hand-computed expectations.
module tb_sipo_rx_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a;
  logic         bit_en;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;

  sipo_rx_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .bit_en    (bit_en),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobe with value b, then gap idle cycles (bit_en low); samples land #1 after edges.
  task automatic send_bit(input logic b, input int gap, input logic chkbusy);
    a = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    if (gap > 0) begin
      bit_en = 1'b0;
      a = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (chkbusy) chk("busy_hold", 32'(busy), 32'd1);
      end
    end
  endtask

  // Full frame, MSB first; returns #1 after the stop edge with bit_en still high.
  task automatic frame(input logic [W-1:0] d, input logic stopb, input int gap);
    send_bit(1'b0, gap, 1'b1);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      send_bit(d[W-1-i], gap, 1'b1);
      chk("busy_data", 32'(busy), 32'd1);
    end
    send_bit(stopb, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    a = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b1; bit_en = 1'b0; q_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q",    32'(q),         32'h0);
    chk("rst_qv",   32'(q_valid),   32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_fe",   32'(frame_err), 32'd0);
    chk("rst_ov",   32'(overrun),   32'd0);
    rst = 1'b0;
    idle(2);

    // good frame 0xCB, consumer ready
    q_ready = 1'b1;
    frame(8'hCB, 1'b1, 0);
    chk("t1_q",    32'(q),         32'hCB);
    chk("t1_qv",   32'(q_valid),   32'd1);
    chk("t1_busy", 32'(busy),      32'd0);
    chk("t1_fe",   32'(frame_err), 32'd0);
    chk("t1_ov",   32'(overrun),   32'd0);
    idle(1);
    chk("t1_qv_1cyc", 32'(q_valid), 32'd0);

    // bad stop bit
    frame(8'hCB, 1'b0, 0);
    idle(0);
    bit_en = 1'b0; a = 1'b1;
    chk("t2_fe",   32'(frame_err), 32'd1);
    chk("t2_qv",   32'(q_valid),   32'd0);
    chk("t2_q",    32'(q),         32'hCB);
    chk("t2_busy", 32'(busy),      32'd0);
    chk("t2_ov",   32'(overrun),   32'd0);
    idle(1);
    chk("t2_fe_1cyc", 32'(frame_err), 32'd0);
    chk("t2_busy_idle", 32'(busy),    32'd0);

    // overrun: consumer stalled, two frames back-to-back
    q_ready = 1'b0;
    frame(8'hCB, 1'b1, 0);
    chk("t3_q_a",  32'(q),       32'hCB);
    chk("t3_qv_a", 32'(q_valid), 32'd1);
    frame(8'h35, 1'b1, 0);
    chk("t3_ov",   32'(overrun), 32'd1);
    chk("t3_q_b",  32'(q),       32'hCB);
    chk("t3_qv_b", 32'(q_valid), 32'd1);
    chk("t3_fe",   32'(frame_err), 32'd0);
    idle(1);
    chk("t3_ov_1cyc", 32'(overrun), 32'd0);
    chk("t3_qv_hold", 32'(q_valid), 32'd1);
    q_ready = 1'b1;
    idle(1);
    q_ready = 1'b0;
    chk("t3_consume", 32'(q_valid), 32'd0);
    chk("t3_q_keep",  32'(q),       32'hCB);

    // slow strobe, every 4th cycle
    frame(8'hA5, 1'b1, 3);
    chk("t4_q",    32'(q),       32'hA5);
    chk("t4_qv",   32'(q_valid), 32'd1);
    chk("t4_busy", 32'(busy),    32'd0);
    q_ready = 1'b1;
    idle(1);
    chk("t4_consume", 32'(q_valid), 32'd0);

    // reset after 4th data bit, then a clean frame
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    bit_en = 1'b0; a = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_q",    32'(q),         32'h0);
    chk("t5_qv",   32'(q_valid),   32'd0);
    chk("t5_busy", 32'(busy),      32'd0);
    chk("t5_fe",   32'(frame_err), 32'd0);
    chk("t5_ov",   32'(overrun),   32'd0);
    idle(1);
    chk("t5_fe_after", 32'(frame_err), 32'd0);
    frame(8'h0F, 1'b1, 0);
    chk("t5_q_new",  32'(q),       32'h0F);
    chk("t5_qv_new", 32'(q_valid), 32'd1);

    // back-to-back with consumer always ready
    frame(8'h01, 1'b1, 0);
    chk("t6_q_a",  32'(q),       32'h01);
    chk("t6_qv_a", 32'(q_valid), 32'd1);
    frame(8'h80, 1'b1, 0);
    chk("t6_q_b",  32'(q),       32'h80);
    chk("t6_qv_b", 32'(q_valid), 32'd1);
    chk("t6_ov",   32'(overrun), 32'd0);
    a = 1'b1; bit_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end
    chk("t6_idle_qv", 32'(q_valid), 32'd0);
    bit_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
